// File: rtl/uart_pkg.sv
// Shared UART controller definitions: FSM state encodings and default sizing.
// Reused by both the RX- and TX-side controllers.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE    = 2'd0;
  localparam uart_state_t ACK     = 2'd1;
  localparam uart_state_t HOLDOFF = 2'd2;

  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_ACK_TIMEOUT = 64;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with show-ahead read data and registered occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage for accepted push/pop.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; contents cleared on reset so the head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: acknowledges the Receiver's byte-complete flag,
// queues each byte in a FIFO and reports overrun / stuck-handshake errors.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                     rx_clk,
  input  logic                     reset_n,
  input  logic                     rx_complete_flag,
  input  logic [7:0]               rx_data,
  output logic                     rx_complete_del_flag,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun_flag,
  output logic                     ack_timeout_err,
  input  logic                     err_clr
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  uart_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_q, ack_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic          push_s;
  logic          pop_s;
  logic          ovr_set_s;
  logic          tmo_set_s;
  logic          timer_max_s;
  logic          full_s;
  logic          empty_s;

  assign pop_s       = out_ready && !empty_s;
  assign timer_max_s = (timer_q == TW'(ACK_TIMEOUT - 1));

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rx_clk),
    .rst_n (reset_n),
    .push  (push_s),
    .pop   (out_ready),
    .wdata (rx_data),
    .rdata (out_data),
    .count (fifo_count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid            = !empty_s;
  assign rx_complete_del_flag = ack_q;
  assign overrun_flag         = ovr_q;
  assign ack_timeout_err      = tmo_q;

  // Handshake state and status registers.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state decode of the acknowledge handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_complete_flag) begin
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!rx_complete_flag) begin
          state_d = IDLE;
        end else if (timer_max_s) begin
          state_d = HOLDOFF;
        end else begin
          state_d = ACK;
        end
      end
      HOLDOFF: begin
        if (!rx_complete_flag) begin
          state_d = IDLE;
        end else begin
          state_d = HOLDOFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Push/overrun/timeout events, timer and sticky-flag updates.
  always_comb begin
    push_s    = 1'b0;
    ovr_set_s = 1'b0;
    tmo_set_s = 1'b0;
    timer_d   = '0;
    case (state_q)
      IDLE: begin
        if (rx_complete_flag && (!full_s || pop_s)) begin
          push_s = 1'b1;
        end else if (rx_complete_flag) begin
          ovr_set_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ACK: begin
        if (rx_complete_flag && timer_max_s) begin
          tmo_set_s = 1'b1;
        end else if (rx_complete_flag) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = '0;
        end
      end
      HOLDOFF: timer_d = '0;
      default: timer_d = '0;
    endcase

    ack_d = (state_d == ACK);

    // A set event in the same cycle as err_clr keeps the flag set.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (tmo_set_s) begin
      tmo_d = 1'b1;
    end else if (err_clr) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a vector table for single-cycle behaviour
// plus hand-written handshake, overrun, timeout, error-clear and reset sequences.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       reset_n;
  logic       flag;
  logic [7:0] rx_data;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       ovr;
  logic       tmo;
  logic       err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_ctrl #(.DEPTH(8), .ACK_TIMEOUT(64)) dut (
    .rx_clk               (clk),
    .reset_n              (reset_n),
    .rx_complete_flag     (flag),
    .rx_data              (rx_data),
    .rx_complete_del_flag (ack),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .fifo_count           (fifo_count),
    .overrun_flag         (ovr),
    .ack_timeout_err      (tmo),
    .err_clr              (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
    logic       ready;
    logic       clr;
    logic       e_ack;
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_cnt;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compliant receiver: flag sampled high on three edges, then low.
  task automatic send_byte(input logic [7:0] b);
    flag    = 1'b1;
    rx_data = b;
    tick();
    tick();
    tick();
    flag = 1'b0;
    tick();
  endtask

  logic [7:0] exp_q [8];
  int         ack_cnt;
  int         first_tmo;

  initial begin
    reset_n   = 1'b0;
    flag      = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    //            flag  data   rdy   clr   ack   vld   head   cnt   ovr
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0};
    tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd2, 1'b0};
    tbl[8]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd2, 1'b0};
    tbl[9]  = '{1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd2, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 4'd1, 1'b0};
    tbl[11] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'd1, 1'b0};
    tbl[12] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};

    #12;
    check("rst_ack",   32'(ack),        32'd0);
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_data",  32'(out_data),   32'h00);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovr",   32'(ovr),        32'd0);
    check("rst_tmo",   32'(tmo),        32'd0);
    reset_n = 1'b1;
    tick();

    // Single byte, framing pulse and simultaneous push/pop vectors.
    for (int i = 0; i < 14; i++) begin
      flag      = tbl[i].flag;
      rx_data   = tbl[i].data;
      out_ready = tbl[i].ready;
      err_clr   = tbl[i].clr;
      tick();
      check($sformatf("vec%0d_ack", i),   32'(ack),        32'(tbl[i].e_ack));
      check($sformatf("vec%0d_valid", i), 32'(out_valid),  32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
      end
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_ovr", i),   32'(ovr),        32'(tbl[i].e_ovr));
    end
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Fill and overrun.
    for (int i = 0; i < 9; i++) begin
      send_byte(8'(i));
      if (i == 7) begin
        check("fill8_count", 32'(fifo_count), 32'd8);
        check("fill8_ovr",   32'(ovr),        32'd0);
      end
    end
    check("ovr9_count", 32'(fifo_count), 32'd8);
    check("ovr9_ovr",   32'(ovr),        32'd1);
    check("ovr9_head",  32'(out_data),   32'h00);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_ovr", 32'(ovr), 32'd0);

    // Push and pop in the same cycle while full.
    flag      = 1'b1;
    rx_data   = 8'hAA;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fullpp_count", 32'(fifo_count), 32'd8);
    check("fullpp_ovr",   32'(ovr),        32'd0);
    tick();
    tick();
    flag = 1'b0;
    tick();
    check("fullpp_ovr2",  32'(ovr),        32'd0);
    for (int i = 0; i < 7; i++) exp_q[i] = 8'(i + 1);
    exp_q[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_data", i),  32'(out_data),  32'(exp_q[i]));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("drained_valid", 32'(out_valid),  32'd0);
    check("drained_count", 32'(fifo_count), 32'd0);

    // Stuck flag: 200 cycles high.
    flag      = 1'b1;
    rx_data   = 8'h77;
    ack_cnt   = 0;
    first_tmo = 0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (ack) ack_cnt++;
      if (tmo && first_tmo == 0) first_tmo = t;
    end
    check("stuck_ack_cycles", 32'(ack_cnt),    32'd64);
    check("stuck_tmo_cycle",  32'(first_tmo),  32'd65);
    check("stuck_count",      32'(fifo_count), 32'd1);
    check("stuck_head",       32'(out_data),   32'h77);
    flag = 1'b0;
    tick();
    check("holdoff_exit_ack", 32'(ack), 32'd0);
    send_byte(8'h78);
    check("after_holdoff_count", 32'(fifo_count), 32'd2);

    // Error clear: build an overrun while the timeout flag is set.
    for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i));
    check("both_ovr", 32'(ovr), 32'd1);
    check("both_tmo", 32'(tmo), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr_ovr", 32'(ovr), 32'd0);
    check("errclr_tmo", 32'(tmo), 32'd0);
    flag    = 1'b1;
    rx_data = 8'h99;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("setwins_ovr", 32'(ovr), 32'd1);
    check("setwins_tmo", 32'(tmo), 32'd0);
    tick();
    tick();
    flag = 1'b0;
    tick();

    // Reset mid-ACK with three bytes queued.
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    out_ready = 1'b0;
    check("pre_rst_empty", 32'(out_valid), 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    flag    = 1'b1;
    rx_data = 8'h04;
    tick();
    check("midack_ack",   32'(ack),        32'd1);
    check("midack_count", 32'(fifo_count), 32'd4);
    #2;
    reset_n = 1'b0;
    flag    = 1'b0;
    #1;
    check("async_rst_ack",   32'(ack),        32'd0);
    check("async_rst_valid", 32'(out_valid),  32'd0);
    check("async_rst_data",  32'(out_data),   32'h00);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_ovr",   32'(ovr),        32'd0);
    check("async_rst_tmo",   32'(tmo),        32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send_byte(8'h3C);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_data",  32'(out_data),   32'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
